// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg -- shared op encodings, FSM state type and constants for the
//               RV32M iterative multiply/divide unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_fixup.sv
// ============================================================================
// muldiv_fixup -- combinational sign correction, result selection and
//                 RISC-V special-case override for the muldiv datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_fixup
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [2:0]        op_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic              neg_a_i,
  input  logic              neg_b_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  output logic [XLEN-1:0]   result_o
);

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic              is_rem;

  // Sign flags are already zero for unsigned operands, so one XOR covers MULH and MULHSU.
  assign prod_s = (neg_a_i ^ neg_b_i) ? -acc_i : acc_i;
  assign quot_s = (neg_a_i ^ neg_b_i) ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
  assign rem_s  = neg_a_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
  assign is_rem = op_i[1];

  always_comb begin
    result_o = '0;
    if (!op_is_div(op_i)) begin
      result_o = (op_i == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (rs2_i == '0) begin
      result_o = is_rem ? rs1_i : DIV0_QUOT;
    end else if (!op_i[0] && rs1_i == INT_MIN && rs2_i == '1) begin
      result_o = is_rem ? '0 : INT_MIN;
    end else begin
      result_o = is_rem ? rem_s : quot_s;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit -- iterative radix-2 RV32M multiply/divide unit (34-cycle path).
// Optional MULDIV_FASTPATH_EN: trivial/special ops skip CALC (2-cycle path).
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic [4:0]      rd_in_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_out_o,
  output logic            wb_en_o
);

  localparam int CW = $clog2(XLEN);

  state_e            state_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, opnd_q, result_q;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_init;
  logic              neg_a_q, neg_b_q, done_q, wb_en_q;
  logic [CW-1:0]     cnt_q;
  logic [4:0]        rd_q;

  logic              sgn_a, sgn_b, neg_a, neg_b, fast, mul_zero;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     sum, rem_sh, diff;
  logic [XLEN-1:0]   fix_result;

  assign sgn_a = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign sgn_b = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign neg_a = sgn_a & rs1_val_i[XLEN-1];
  assign neg_b = sgn_b & rs2_val_i[XLEN-1];
  assign a_mag = neg_a ? -rs1_val_i : rs1_val_i;
  assign b_mag = neg_b ? -rs2_val_i : rs2_val_i;

`ifdef MULDIV_FASTPATH_EN
  assign mul_zero = !op_is_div(op_i) && (rs1_val_i == '0 || rs2_val_i == '0);
  assign fast = mul_zero
             || (op_is_div(op_i) && rs2_val_i == '0)
             || ((op_i == OP_DIV || op_i == OP_REM) && rs1_val_i == INT_MIN && rs2_val_i == '1);
`else
  assign mul_zero = 1'b0;
  assign fast     = 1'b0;
`endif

  // Multiply keeps the multiplier in the low half and adds the multiplicand on top;
  // divide keeps the dividend in the low half and compares the divisor against the top.
  assign acc_init = mul_zero ? '0
                  : {{XLEN{1'b0}}, op_is_div(op_i) ? a_mag : b_mag};

  always_comb begin
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    acc_d  = {sum, acc_q[XLEN-1:1]};
    if (op_is_div(op_q)) begin
      acc_d = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  muldiv_fixup #(.XLEN(XLEN)) u_fixup (
    .op_i     (op_q),
    .acc_i    (acc_q),
    .neg_a_i  (neg_a_q),
    .neg_b_i  (neg_b_q),
    .rs1_i    (rs1_q),
    .rs2_i    (rs2_q),
    .result_o (fix_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      wb_en_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q  <= 1'b0;
          wb_en_q <= 1'b0;
          if (start_i && !kill_i) begin
            op_q    <= op_i;
            rs1_q   <= rs1_val_i;
            rs2_q   <= rs2_val_i;
            rd_q    <= rd_in_i;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            opnd_q  <= op_is_div(op_i) ? b_mag : a_mag;
            acc_q   <= acc_init;
            cnt_q   <= '0;
            state_q <= fast ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (kill_i) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            if (cnt_q == CW'(XLEN - 1)) begin
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_FIX: begin
          if (kill_i) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= fix_result;
            done_q   <= 1'b1;
            wb_en_q  <= (rd_q != 5'd0);
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          wb_en_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign wb_en_o  = wb_en_q;
  assign result_o = result_q;
  assign rd_out_o = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit -- self-checking bench for muldiv_unit: directed RV32M
//                   vectors, control events and randomized ops vs. a model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd = '0;
  logic        kill = 1'b0;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .op_i      (op),
    .rs1_val_i (rs1),
    .rs2_val_i (rs2),
    .rd_in_i   (rd),
    .kill_i    (kill),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .rd_out_o  (rd_out),
    .wb_en_o   (wb_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with plain 64-bit / int arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    int              ia = a;
    int              ib = b;
    logic [63:0]     p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
    if (o[2] && b == 0) return 2;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    if (!o[2] && (a == 0 || b == 0)) return 2;
`endif
    return 34;
  endfunction

  // Leaves the bench at the negedge one cycle after the start cycle.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b; rd = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_op(input logic [31:0] exp_res, input logic [4:0] exp_rd, input int lat, input int n0);
    int   n = n0;
    logic busy_bad = 1'b0;
    while (done !== 1'b1 && n < 60) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    check("busy_during", {31'b0, busy_bad}, 32'd0);
    check("busy_at_done", {31'b0, busy}, 32'd1);
    check("result", result, exp_res);
    check("rd_out", {27'b0, rd_out}, {27'b0, exp_rd});
    check("wb_en", {31'b0, wb_en}, {31'b0, exp_rd != 5'd0});
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd0);
    check("busy_after", {31'b0, busy}, 32'd0);
    last_res = exp_res;
  endtask

  task automatic run_chk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] exp_res);
    launch(o, a, b, r);
    finish_op(exp_res, r, exp_lat(o, a, b), 1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic seen_done;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_wb_en", {31'b0, wb_en}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", {27'b0, rd_out}, 32'd0);
    rst_n = 1'b1;

    run_chk(3'd0, 32'd7, 32'd2, 5'd11, 32'h0000_000E);
    run_chk(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    run_chk(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    run_chk(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF);
    run_chk(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    run_chk(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF);
    run_chk(3'd5, 32'h0000_FFFF, 32'd3, 5'd6, 32'h0000_5555);
    run_chk(3'd7, 32'h0000_FFFF, 32'd3, 5'd7, 32'h0000_0000);
    run_chk(3'd4, 32'd7, 32'd0, 5'd8, 32'hFFFF_FFFF);
    run_chk(3'd6, 32'd7, 32'd0, 5'd9, 32'd7);
    run_chk(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
    run_chk(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000);
    run_chk(3'd0, 32'd3, 32'd7, 5'd0, 32'h0000_0015);

    // Second start mid-CALC must be ignored.
    launch(3'd0, 32'd100, 32'd5, 5'd13);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd5; rs1 = 32'd9; rs2 = 32'd4; rd = 5'd14;
    @(negedge clk);
    start = 1'b0;
    finish_op(32'd500, 5'd13, 34, 6);

    // Kill at cycle 10: busy drops, no done, result retained.
    launch(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || wb_en === 1'b1) seen_done = 1'b1;
    end
    check("kill_no_done", {31'b0, seen_done}, 32'd0);
    check("kill_result", result, last_res);

    // Kill together with start in IDLE: start is not accepted.
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd = 5'd1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_start_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset at cycle 20, then a clean op.
    launch(3'd5, 32'hDEAD_BEEF, 32'd17, 5'd20);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_rd_out", {27'b0, rd_out}, 32'd0);
    check("arst_wb_en", {31'b0, wb_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk(3'd5, 32'hDEAD_BEEF, 32'd17, 5'd20, model(3'd5, 32'hDEAD_BEEF, 32'd17));

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      logic [4:0]  rr;
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      rr = 5'($urandom_range(0, 31));
      run_chk(ro, ra, rb, rr, model(ro, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
